traffic_light_fsm: RTL and testbench
====================================

Name: traffic_light_fsm

Overview:
- Single-approach traffic-light sequencer: a cyclic Moore FSM RED -> GREEN -> YELLOW -> RED.
- Each phase is held for a parameterised number of clock cycles using an internal down-counter.
- Drives a 3-bit one-hot lamp vector; standalone leaf block with no handshake inputs.

Parameters:
- RED_CYCLES, 4, clock cycles spent in RED (legal range 1..255).
- GREEN_CYCLES, 5, clock cycles spent in GREEN (legal range 1..255).
- YELLOW_CYCLES, 2, clock cycles spent in YELLOW (legal range 1..255).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- light  output  3  one-hot lamp drive: bit2 = red, bit1 = yellow, bit0 = green.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset:
  - While reset=0: state=RED, light=3'b100 immediately (no clock needed).
  - Phase counter loads RED_CYCLES-1.
- States and encodings:
  - RED: light=3'b100.
  - GREEN: light=3'b001.
  - YELLOW: light=3'b010.
  - light is a registered/decoded function of the state only (Moore); exactly one bit is set at all times.
- Counter:
  - Width CNT_W = 8 bits.
  - On entry to a phase, load (phase_CYCLES-1).
  - Decrement by 1 each rising edge while nonzero.
  - When counter==0 at a rising edge, advance to the next state and load that state's value.
- Transitions: RED -> GREEN -> YELLOW -> RED, repeating forever.
- Phase length: each phase lasts exactly its parameter's cycle count. A value of 1 means one cycle in that phase.
- First cycle after reset release: the first rising edge with reset=1 is cycle 1 of RED. With defaults, GREEN appears after edge 4, YELLOW after edge 9, RED after edge 11; period = 11 cycles.
- Reset mid-phase: asserting reset at any time forces RED and reloads the counter asynchronously. The sequence restarts as from power-up after release.
- Illegal state encodings (2-bit state, code 2'b11): next edge goes to RED with counter reloaded to RED_CYCLES-1. light is 3'b100 while in the illegal code.
- Parameter values of 0 or >255 are illegal; elaboration-time check with $error.

Optional Feature:
- Macro TLF_DEBUG_EN.
- When defined, adds output ports:
  - state_dbg [1:0]: RED=2'b00, GREEN=2'b01, YELLOW=2'b10.
  - timer_dbg [7:0]: current counter value.
  - Both reset to 2'b00 and RED_CYCLES-1.
- When undefined, these ports and their logic are absent.
- Lamp behaviour is identical in both builds.

Decomposition:
- Package traffic_light_pkg holds:
  - state typedef/localparams (ST_RED, ST_GREEN, ST_YELLOW).
  - lamp constants (LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001).
  - CNT_W=8.
- One sub-module is natural: tlf_phase_timer, a loadable 8-bit down-counter with a zero flag. The FSM and output decode stay in the top.

Test Plan:
- Hold reset=0 for 10 time units, then release -> light=3'b100 immediately while reset=0; with defaults, stays 100 for 4 rising edges.
- Run 11+ cycles after release with defaults -> light sequence 100 x4, 001 x5, 010 x2, then 100 again. Count per-phase cycles exactly.
- Assert reset=0 asynchronously mid-GREEN (between clock edges) -> light becomes 3'b100 without waiting for clk. After release, RED lasts a full 4 cycles.
- Parameter override RED=1, GREEN=1, YELLOW=1 -> light changes every cycle: 100, 001, 010, 100 ...
- Every cycle, across 50 cycles of free running -> light is one-hot (popcount==1), and no GREEN->RED or RED->YELLOW transition occurs.
- With TLF_DEBUG_EN defined -> state_dbg tracks light (00/01/10), and timer_dbg counts 3,2,1,0 in RED with default parameters.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic-light sequencer.
// Lamp vector layout: bit2 = red, bit1 = yellow, bit0 = green.
package traffic_light_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_e;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // The unused code 2'b11 shows red so the lamps never go dark or doubled.
  function automatic logic [2:0] light_of(input state_e s);
    case (s)
      ST_GREEN:  return LIGHT_GREEN;
      ST_YELLOW: return LIGHT_YELLOW;
      default:   return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/tlf_phase_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
// Asynchronous active-low reset preloads RESET_VAL.
module tlf_phase_timer
  import traffic_light_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/traffic_light_fsm.sv
// Cyclic RED -> GREEN -> YELLOW Moore sequencer with per-phase cycle counts.
// Define TLF_DEBUG_EN to expose state_dbg / timer_dbg observation ports.
module traffic_light_fsm
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = 4,
  parameter int GREEN_CYCLES  = 5,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] light
`ifdef TLF_DEBUG_EN
  ,
  output logic [1:0] state_dbg,
  output logic [7:0] timer_dbg
`endif
);

  if (RED_CYCLES < 1 || RED_CYCLES > 255) begin : g_bad_red
    $error("RED_CYCLES must be in 1..255");
  end
  if (GREEN_CYCLES < 1 || GREEN_CYCLES > 255) begin : g_bad_green
    $error("GREEN_CYCLES must be in 1..255");
  end
  if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > 255) begin : g_bad_yellow
    $error("YELLOW_CYCLES must be in 1..255");
  end

  // Counter holds (cycles - 1) on entry so a phase lasts exactly its count.
  localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_zero;
`ifdef TLF_DEBUG_EN
  logic [CNT_W-1:0] w_count;
`else
  logic [CNT_W-1:0] w_unused_count;
`endif

  tlf_phase_timer #(
    .RESET_VAL (RED_LOAD)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
`ifdef TLF_DEBUG_EN
    .o_count    (w_count),
`else
    .o_count    (w_unused_count),
`endif
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = RED_LOAD;
    case (r_state)
      ST_RED: begin
        if (w_zero) begin
          w_state_next = ST_GREEN;
          w_load       = 1'b1;
          w_load_val   = GREEN_LOAD;
        end
      end
      ST_GREEN: begin
        if (w_zero) begin
          w_state_next = ST_YELLOW;
          w_load       = 1'b1;
          w_load_val   = YELLOW_LOAD;
        end
      end
      ST_YELLOW: begin
        if (w_zero) begin
          w_state_next = ST_RED;
          w_load       = 1'b1;
          w_load_val   = RED_LOAD;
        end
      end
      default: begin
        // Recover from the unused encoding straight into a fresh RED phase.
        w_state_next = ST_RED;
        w_load       = 1'b1;
        w_load_val   = RED_LOAD;
      end
    endcase
  end

  assign light = light_of(r_state);

`ifdef TLF_DEBUG_EN
  assign state_dbg = r_state;
  assign timer_dbg = w_count;
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench: default-parameter DUT plus an all-ones-cycle DUT.
// Build with TLF_DEBUG_EN defined to also check state_dbg / timer_dbg.
module tb_traffic_light_fsm;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;
  localparam int N_VEC = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] light;
  logic [2:0] light_fast;
`ifdef TLF_DEBUG_EN
  logic [1:0] state_dbg;
  logic [7:0] timer_dbg;
  logic [1:0] state_dbg_fast;
  logic [7:0] timer_dbg_fast;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0] exp_light;
    logic [2:0] exp_fast;
    logic [1:0] exp_state;
    logic [7:0] exp_timer;
  } vec_t;

  vec_t vecs[N_VEC];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  traffic_light_fsm u_dut (
    .clk       (clk),
    .reset     (reset),
    .light     (light)
`ifdef TLF_DEBUG_EN
    ,
    .state_dbg (state_dbg),
    .timer_dbg (timer_dbg)
`endif
  );

  traffic_light_fsm #(
    .RED_CYCLES    (1),
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1)
  ) u_dut_fast (
    .clk       (clk),
    .reset     (reset),
    .light     (light_fast)
`ifdef TLF_DEBUG_EN
    ,
    .state_dbg (state_dbg_fast),
    .timer_dbg (timer_dbg_fast)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Applies the first n vectors starting from the current between-edges point.
  task automatic run_vectors(input int n, input string tag);
    logic [2:0] prev;
    logic [2:0] prev_fast;
    vec_t       e;
    prev      = 3'b000;
    prev_fast = 3'b000;
    for (int k = 0; k < n; k++) begin
      sb_q.push_back(vecs[k]);
      e = sb_q.pop_front();
      $display("%s cycle %0d: light=%b fast=%b", tag, k, light, light_fast);
      chk({tag, "_light"}, {5'b0, light}, {5'b0, e.exp_light});
      chk({tag, "_fast_light"}, {5'b0, light_fast}, {5'b0, e.exp_fast});
      chk({tag, "_onehot"}, 8'($countones(light)), 8'd1);
      if (k > 0) begin
        chk({tag, "_bad_transition"},
            {7'b0, (prev == L_GREEN && light == L_RED) || (prev == L_RED && light == L_YELLOW)},
            8'd0);
        chk({tag, "_fast_bad_transition"},
            {7'b0, (prev_fast == L_GREEN && light_fast == L_RED) ||
                   (prev_fast == L_RED && light_fast == L_YELLOW)},
            8'd0);
      end
`ifdef TLF_DEBUG_EN
      chk({tag, "_state_dbg"}, {6'b0, state_dbg}, {6'b0, e.exp_state});
      chk({tag, "_timer_dbg"}, timer_dbg, e.exp_timer);
`endif
      prev      = light;
      prev_fast = light_fast;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int pos;
    reset = 1'b0;

    // Expected waveform for defaults 4/5/2 (period 11) and for 1/1/1 (period 3).
    for (int k = 0; k < N_VEC; k++) begin
      pos = k % 11;
      if (pos < 4) begin
        vecs[k].exp_light = L_RED;
        vecs[k].exp_state = 2'b00;
        vecs[k].exp_timer = 8'(3 - pos);
      end else if (pos < 9) begin
        vecs[k].exp_light = L_GREEN;
        vecs[k].exp_state = 2'b01;
        vecs[k].exp_timer = 8'(8 - pos);
      end else begin
        vecs[k].exp_light = L_YELLOW;
        vecs[k].exp_state = 2'b10;
        vecs[k].exp_timer = 8'(10 - pos);
      end
      case (k % 3)
        0:       vecs[k].exp_fast = L_RED;
        1:       vecs[k].exp_fast = L_GREEN;
        default: vecs[k].exp_fast = L_YELLOW;
      endcase
    end

    // While held in reset.
    #7;
    chk("reset_light", {5'b0, light}, {5'b0, L_RED});
    chk("reset_fast_light", {5'b0, light_fast}, {5'b0, L_RED});
`ifdef TLF_DEBUG_EN
    chk("reset_state_dbg", {6'b0, state_dbg}, 8'd0);
    chk("reset_timer_dbg", timer_dbg, 8'd3);
`endif
    #3;
    reset = 1'b1;
    #1;
    run_vectors(N_VEC, "run");

    // 60 cycles in: second cycle of GREEN. Pull reset between clock edges.
    chk("pre_reset_green", {5'b0, light}, {5'b0, L_GREEN});
    #2;
    reset = 1'b0;
    #1;
    $display("async reset mid-GREEN: light=%b fast=%b", light, light_fast);
    chk("async_reset_light", {5'b0, light}, {5'b0, L_RED});
    chk("async_reset_fast_light", {5'b0, light_fast}, {5'b0, L_RED});
`ifdef TLF_DEBUG_EN
    chk("async_reset_state_dbg", {6'b0, state_dbg}, 8'd0);
    chk("async_reset_timer_dbg", timer_dbg, 8'd3);
`endif
    @(negedge clk);
    chk("held_reset_light", {5'b0, light}, {5'b0, L_RED});
    reset = 1'b1;
    #1;
    run_vectors(12, "rerun");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
